fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that drives the IF/ID pipeline register. It owns the PC and issues one-outstanding-request fetches to instruction memory over a req/ack handshake. It buffers returned words in an output register plus a 1-entry skid buffer, so hazard stalls lose nothing, and it flushes on branch redirect. It also decodes the immediate-format select (immode) for the IF/ID register from the presented instruction.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_ctrl_if.sv | 26 ++
 rtl/immode_decode.sv | 23 ++
 rtl/fetch_ctrl.sv | 117 +++++++++++
 tb/tb_fetch_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: RV32 opcodes used for
// immediate-format selection, immediate-format codes, the canonical NOP and
// the fetch sequencer state type.
package fetch_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } immode_t;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus. The fetch sequencer is the
// master; the instruction memory (or its model) is the slave.
interface fetch_ctrl_if #(
    parameter int unsigned WordSize = 32
);

    logic                imem_req;
    logic [WordSize-1:0] imem_addr;
    logic                imem_ack;
    logic [31:0]         imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/immode_decode.sv
// Opcode to immediate-format decoder. Purely combinational so the decode
// stage can reuse it on its own copy of the instruction.
module immode_decode
    import fetch_pkg::*;
(
    input  logic [6:0] opcode,
    output immode_t    mode
);

    // Map the major opcode onto its immediate encoding; unknown opcodes carry none.
    always_comb begin
        mode = IMM_NONE;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: mode = IMM_I;
            OP_STORE:                 mode = IMM_S;
            OP_BRANCH:                mode = IMM_B;
            OP_LUI, OP_AUIPC:         mode = IMM_U;
            OP_JAL:                   mode = IMM_J;
            default:                  mode = IMM_NONE;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer feeding the IF/ID register. Keeps one fetch
// outstanding at a time, holds returned words in an output register backed
// by a one-entry skid buffer so IF/ID stalls never drop a word, and flushes
// on redirect. A request that is in flight when a redirect arrives cannot be
// withdrawn, so it is drained at its original address and its data dropped.
// The interface instance must be built with the same WordSize as this module.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned         WordSize    = 32,
    parameter logic [WordSize-1:0] ResetVector = '0
) (
    input  logic                clk,
    input  logic                rstn,
    fetch_ctrl_if.master        imem,
    input  logic                stall,
    input  logic                redirect,
    input  logic [WordSize-1:0] redirect_pc,
    output logic [31:0]         ins_out,
    output logic [WordSize-1:0] pc_out,
    output logic                ins_valid,
    output logic [2:0]          immode
);

    localparam logic [WordSize-1:0] PcStep = WordSize'(4);

    fetch_state_t        state;
    logic [WordSize-1:0] pc_q;
    logic [WordSize-1:0] drain_addr;
    logic                skid_valid;
    logic [31:0]         skid_ins;
    logic [WordSize-1:0] skid_pc;

    logic                accept;
    logic                consume;
    logic [WordSize-1:0] redirect_target;
    immode_t             mode;
    logic                unused_redirect_lsbs;

    // The request is a pure function of registered state, so it cannot glitch
    // and it stays asserted at a fixed address until the acknowledge lands.
    assign imem.imem_req  = (state == ST_DRAIN) || ((state == ST_FETCH) && !skid_valid);
    assign imem.imem_addr = (state == ST_DRAIN) ? drain_addr : pc_q;

    assign accept          = imem.imem_req && imem.imem_ack;
    assign consume         = ins_valid && !stall;
    assign redirect_target = {redirect_pc[WordSize-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Sequencer, PC, output register and skid buffer; redirect wins over all else.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_BOOT;
            pc_q       <= ResetVector;
            drain_addr <= '0;
            skid_valid <= 1'b0;
            skid_ins   <= NOP_INSN;
            skid_pc    <= '0;
            ins_valid  <= 1'b0;
            ins_out    <= NOP_INSN;
            pc_out     <= '0;
        end else if (redirect) begin
            ins_valid  <= 1'b0;
            ins_out    <= NOP_INSN;
            skid_valid <= 1'b0;
            pc_q       <= redirect_target;
            case (state)
                ST_BOOT:  state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem.imem_req && !imem.imem_ack) begin
                        state      <= ST_DRAIN;
                        drain_addr <= pc_q;
                    end
                end
                // An ack here retires the stale request, so fetching can resume.
                ST_DRAIN: if (imem.imem_ack) state <= ST_FETCH;
                default:  state <= ST_BOOT;
            endcase
        end else begin
            case (state)
                ST_BOOT:  state <= ST_FETCH;
                ST_DRAIN: if (imem.imem_ack) state <= ST_FETCH;
                ST_FETCH: begin
                    if (accept) pc_q <= pc_q + PcStep;
                    if (consume && skid_valid) begin
                        ins_out    <= skid_ins;
                        pc_out     <= skid_pc;
                        ins_valid  <= 1'b1;
                        skid_valid <= accept;
                        skid_ins   <= imem.imem_rdata;
                        skid_pc    <= pc_q;
                    end else if (accept && (!ins_valid || consume)) begin
                        ins_out   <= imem.imem_rdata;
                        pc_out    <= pc_q;
                        ins_valid <= 1'b1;
                    end else if (accept) begin
                        skid_ins   <= imem.imem_rdata;
                        skid_pc    <= pc_q;
                        skid_valid <= 1'b1;
                    end else if (consume) begin
                        ins_valid <= 1'b0;
                        ins_out   <= NOP_INSN;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

    immode_decode u_immode_decode (
        .opcode (ins_out[6:0]),
        .mode   (mode)
    );

    assign immode = mode;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with cycle-exact expectations,
// then a randomized stall/ack/redirect run scored against an in-order
// delivery model of the instruction stream.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] ins_out;
    logic [31:0] pc_out;
    logic        ins_valid;
    logic [2:0]  immode;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] prog [6] = '{32'h00500093, 32'h00112023, 32'h00000463,
                              32'h000012B7, 32'h0080006F, 32'h00B50533};
    logic [2:0]  prog_imm [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

    fetch_ctrl_if #(.WordSize(32)) bus ();

    fetch_ctrl #(.WordSize(32), .ResetVector(32'h0)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .imem        (bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ins_out     (ins_out),
        .pc_out      (pc_out),
        .ins_valid   (ins_valid),
        .immode      (immode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd24) return prog[int'(a >> 2)];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    function automatic logic [2:0] ref_immode(input logic [31:0] w);
        case (w[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: return 3'd1;
            7'b0100011:                         return 3'd2;
            7'b1100011:                         return 3'd3;
            7'b0110111, 7'b0010111:             return 3'd4;
            7'b1101111:                         return 3'd5;
            default:                            return 3'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ack);
        rstn = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        bus.imem_ack = ack;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Presented instruction: validity, and when valid its PC, word and format.
    task automatic expect_out(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(ins_valid), 32'(v));
        if (v) begin
            chk({tag, "_pc"}, pc_out, pc);
            chk({tag, "_ins"}, ins_out, mem_word(pc));
            chk({tag, "_immode"}, 32'(immode), 32'(ref_immode(mem_word(pc))));
        end else begin
            chk({tag, "_nop"}, ins_out, NOP);
            chk({tag, "_immode"}, 32'(immode), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic [31:0] rp;
        logic        prev_pending;
        logic        flush_expect;
        int          consumed;

        // Reset state and back-to-back streaming with the format table.
        do_reset(1'b1);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_pc_out", pc_out, 32'h0);
        expect_out("rst", 1'b0, 32'h0);
        tick();
        chk("boot_req", 32'(bus.imem_req), 32'd1);
        chk("boot_addr", bus.imem_addr, 32'h0);
        chk("boot_valid", 32'(ins_valid), 32'd0);
        for (int k = 2; k < 8; k++) begin
            tick();
            expect_out("stream", 1'b1, 32'(4 * (k - 2)));
            chk("stream_addr", bus.imem_addr, 32'(4 * (k - 1)));
            chk("stream_immode", 32'(immode), 32'(prog_imm[k - 2]));
        end

        // Stall with ack tied high: skid captures pc 4, request drops.
        do_reset(1'b1);
        tick();
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out("stall_hold", 1'b1, 32'h0);
            chk("stall_req", 32'(bus.imem_req), 32'd0);
        end
        stall = 1'b0;
        tick();
        expect_out("stall_rel1", 1'b1, 32'h4);
        chk("stall_rel1_req", 32'(bus.imem_req), 32'd1);
        chk("stall_rel1_addr", bus.imem_addr, 32'h8);
        tick();
        expect_out("stall_rel2", 1'b1, 32'h8);
        chk("stall_rel2_addr", bus.imem_addr, 32'hC);

        // Redirect while a slow request is outstanding: drain, then refetch.
        do_reset(1'b0);
        tick();
        chk("drain_req0", 32'(bus.imem_req), 32'd1);
        chk("drain_addr0", bus.imem_addr, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("drain_req", 32'(bus.imem_req), 32'd1);
            chk("drain_addr", bus.imem_addr, 32'h0);
            expect_out("drain", 1'b0, 32'h0);
            if (k == 0) tick();
        end
        bus.imem_ack = 1'b1;
        tick();
        expect_out("drain_done", 1'b0, 32'h0);
        chk("drain_new_addr", bus.imem_addr, 32'h100);
        tick();
        expect_out("drain_first", 1'b1, 32'h100);

        // Redirect to an unaligned target while the skid is full.
        do_reset(1'b1);
        tick();
        tick();
        stall = 1'b1;
        tick();
        chk("flush_pre_req", 32'(bus.imem_req), 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'h203;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        expect_out("flush", 1'b0, 32'h0);
        chk("flush_addr", bus.imem_addr, 32'h200);
        tick();
        expect_out("flush_first", 1'b1, 32'h200);
        chk("flush_next_addr", bus.imem_addr, 32'h204);
        tick();
        expect_out("flush_second", 1'b1, 32'h204);

        // Asynchronous reset in the middle of a pending request.
        do_reset(1'b1);
        tick();
        tick();
        tick();
        bus.imem_ack = 1'b0;
        chk("areset_pre_req", 32'(bus.imem_req), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("areset_req", 32'(bus.imem_req), 32'd0);
        chk("areset_pc_out", pc_out, 32'h0);
        expect_out("areset", 1'b0, 32'h0);
        tick();
        tick();
        rstn = 1'b1;
        chk("areset_boot_req", 32'(bus.imem_req), 32'd0);
        tick();
        chk("areset_fetch_req", 32'(bus.imem_req), 32'd1);
        chk("areset_fetch_addr", bus.imem_addr, 32'h0);
        bus.imem_ack = 1'b1;
        tick();
        expect_out("areset_first", 1'b1, 32'h0);

        // Randomized stall/ack/redirect against an in-order delivery model.
        do_reset(1'b0);
        exp_pc = 32'h0;
        prev_pending = 1'b0;
        prev_addr = '0;
        flush_expect = 1'b0;
        consumed = 0;
        for (int n = 0; n < 2000; n++) begin
            tick();
            if (prev_pending) begin
                chk("rnd_req_hold", 32'(bus.imem_req), 32'd1);
                chk("rnd_addr_hold", bus.imem_addr, prev_addr);
            end
            if (flush_expect) chk("rnd_flush", 32'(ins_valid), 32'd0);
            if (ins_valid) begin
                chk("rnd_pc", pc_out, exp_pc);
                chk("rnd_ins", ins_out, mem_word(exp_pc));
            end else begin
                chk("rnd_nop", ins_out, NOP);
            end
            chk("rnd_immode", 32'(immode), 32'(ref_immode(ins_valid ? mem_word(exp_pc) : NOP)));

            stall = ($urandom_range(0, 9) < 3);
            bus.imem_ack = $urandom_range(0, 1) == 1;
            redirect = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
            else rp = $urandom & 32'h0000_03FF;
            redirect_pc = rp;

            prev_pending = bus.imem_req && !bus.imem_ack;
            prev_addr = bus.imem_addr;
            if (redirect) begin
                exp_pc = rp & ~32'h3;
                flush_expect = 1'b1;
            end else begin
                flush_expect = 1'b0;
                if (ins_valid && !stall) begin
                    exp_pc = exp_pc + 32'd4;
                    consumed++;
                end
            end
        end
        redirect = 1'b0;
        chk("rnd_progress", 32'(consumed >= 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
